// File: rtl/ioctl_tx.sv
// ioctl download transmitter: replays a valid/ready byte stream as a framed
// ioctl session with fixed strobe width and minimum strobe spacing.
module ioctl_tx #(
    parameter int ADDR_W = 25,
    parameter int WR_LEN = 1,
    parameter int GAP    = 8,
    parameter int TAIL   = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        index_in,
    input  logic [ADDR_W-1:0] length,
    input  logic [7:0]        src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              busy,
    output logic              done,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout
);

    localparam int CNT_W  = $clog2(GAP + 1);
    localparam int TCNT_W = (TAIL > 1) ? $clog2(TAIL) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  WR_LEN_C  = CNT_W'(WR_LEN);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
    localparam logic [TCNT_W-1:0] TAIL_LAST = TCNT_W'(TAIL - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_SRC,
        STROBE,
        SPACE,
        TAIL_S
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   last_addr;
    logic [7:0]          index_q;
    logic [7:0]          dout_q;
    logic                download_q;
    logic                wr_q;
    logic                done_q;

    assign cnt_d     = cnt_q + CNT_ONE;
    assign last_addr = len_q - ADDR_ONE;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            index_q    <= '0;
            dout_q     <= '0;
            download_q <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        download_q <= 1'b1;
                        index_q    <= index_in;
                        len_q      <= length;
                        addr_q     <= '0;
                        state_q    <= ARM;
                    end
                end
                ARM: begin
                    if (len_q == '0) begin
                        tcnt_q  <= TAIL_LAST;
                        state_q <= TAIL_S;
                    end else begin
                        state_q <= WAIT_SRC;
                    end
                end
                WAIT_SRC: begin
                    if (src_valid) begin
                        dout_q  <= src_data;
                        wr_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= STROBE;
                    end
                end
                STROBE, SPACE: begin
                    cnt_q   <= cnt_d;
                    wr_q    <= (cnt_d < WR_LEN_C);
                    state_q <= (cnt_d < WR_LEN_C) ? STROBE : SPACE;
                    // GAP > WR_LEN, so the strobe is already low when the window closes
                    if (cnt_q == GAP_LAST) begin
                        if (addr_q == last_addr) begin
                            tcnt_q  <= TAIL_LAST;
                            state_q <= TAIL_S;
                        end else begin
                            addr_q  <= addr_q + ADDR_ONE;
                            state_q <= WAIT_SRC;
                        end
                    end
                end
                TAIL_S: begin
                    if (tcnt_q == '0) begin
                        download_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q - TCNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src_ready      = (state_q == WAIT_SRC);
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign ioctl_download = download_q;
    assign ioctl_index    = index_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;

endmodule

// File: tb/tb_ioctl_tx.sv
// Directed bench for ioctl_tx: session vectors for a default instance and a
// WR_LEN=3/GAP=4 instance, plus busy-start and mid-strobe reset sequences.
module tb_ioctl_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;
    logic [7:0]  index_in;
    logic [24:0] length;
    logic [7:0]  src_data;
    logic        src_valid;

    logic        start_d, start_v;
    logic        d_ready, d_busy, d_done, d_dl, d_wr;
    logic [7:0]  d_index, d_dout;
    logic [24:0] d_addr;
    logic        v_ready, v_busy, v_done, v_dl, v_wr;
    logic [7:0]  v_index, v_dout;
    logic [24:0] v_addr;
    logic        m_ready, m_busy, m_done, m_dl, m_wr;
    logic [7:0]  m_index, m_dout;
    logic [24:0] m_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start_d = start & ~sel;
    assign start_v = start & sel;

    ioctl_tx dut (
        .clk_sys(clk), .reset(reset), .start(start_d), .index_in(index_in),
        .length(length), .src_data(src_data), .src_valid(src_valid),
        .src_ready(d_ready), .busy(d_busy), .done(d_done),
        .ioctl_download(d_dl), .ioctl_index(d_index), .ioctl_wr(d_wr),
        .ioctl_addr(d_addr), .ioctl_dout(d_dout)
    );

    ioctl_tx #(.WR_LEN(3), .GAP(4)) dut_v (
        .clk_sys(clk), .reset(reset), .start(start_v), .index_in(index_in),
        .length(length), .src_data(src_data), .src_valid(src_valid),
        .src_ready(v_ready), .busy(v_busy), .done(v_done),
        .ioctl_download(v_dl), .ioctl_index(v_index), .ioctl_wr(v_wr),
        .ioctl_addr(v_addr), .ioctl_dout(v_dout)
    );

    assign m_ready = sel ? v_ready : d_ready;
    assign m_busy  = sel ? v_busy  : d_busy;
    assign m_done  = sel ? v_done  : d_done;
    assign m_dl    = sel ? v_dl    : d_dl;
    assign m_wr    = sel ? v_wr    : d_wr;
    assign m_index = sel ? v_index : d_index;
    assign m_dout  = sel ? v_dout  : d_dout;
    assign m_addr  = sel ? v_addr  : d_addr;

    // bytes/acc hold up to four entries, entry k at bits [8k +: 8];
    // acc and fall are cycle offsets from the start edge
    typedef struct packed {
        logic        var_sel;
        logic [7:0]  idx;
        logic [15:0] len;
        logic [31:0] bytes;
        logic [31:0] acc;
        logic [7:0]  fall;
        logic [3:0]  wr_w;
        logic [7:0]  stall_n;
        logic        poke;
    } vec_t;

    function automatic vec_t mk(logic s, logic [7:0] idx, logic [15:0] len,
                                logic [31:0] b, logic [31:0] acc, logic [7:0] fall,
                                logic [3:0] w, logic [7:0] stall, logic poke);
        vec_t r;
        r.var_sel = s;
        r.idx     = idx;
        r.len     = len;
        r.bytes   = b;
        r.acc     = acc;
        r.fall    = fall;
        r.wr_w    = w;
        r.stall_n = stall;
        r.poke    = poke;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int          rise_cyc[$];
    logic [24:0] rise_addr[$];
    logic [7:0]  rise_dout[$];
    int          widths[$];
    int          w_cur = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          fall_cyc = -1;
    logic        wr_prev = 1'b0;
    logic        dl_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_wr && !wr_prev) begin
                rise_cyc.push_back(cyc);
                rise_addr.push_back(m_addr);
                rise_dout.push_back(m_dout);
                w_cur = 1;
            end else if (m_wr) begin
                w_cur++;
                if (rise_addr.size() > 0) begin
                    chk("hold_addr", 32'(m_addr), 32'(rise_addr[$]));
                    chk("hold_dout", 32'(m_dout), 32'(rise_dout[$]));
                end
            end else if (wr_prev) begin
                widths.push_back(w_cur);
            end
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dl_prev && !m_dl) fall_cyc = cyc;
            wr_prev = m_wr;
            dl_prev = m_dl;
        end
    end

    task automatic feed(input logic [7:0] d, input int stall, input int k);
        int n;
        if (stall > 0) begin
            src_valid = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                if (m_ready) begin
                    chk($sformatf("stall_wr_c%0d", cyc), 32'(m_wr), 32'(0));
                    chk($sformatf("stall_addr_c%0d", cyc), 32'(m_addr), 32'(k));
                end
            end
        end
        src_valid = 1'b1;
        src_data  = d;
        n = 0;
        while (!m_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout byte %0d: src_ready got 0 expected 1", k);
        end else begin
            @(negedge clk);
        end
        src_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int t0, n;
        int exp_last;
        sel = v.var_sel;
        rise_cyc.delete();
        rise_addr.delete();
        rise_dout.delete();
        widths.delete();
        done_cnt = 0;
        done_cyc = -1;
        fall_cyc = -1;
        @(negedge clk);
        start    = 1'b1;
        index_in = v.idx;
        length   = 25'(v.len);
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        chk({tag, "_dl_at_start"}, 32'(m_dl), 32'(1));
        chk({tag, "_busy_at_start"}, 32'(m_busy), 32'(1));
        chk({tag, "_ready_in_arm"}, 32'(m_ready), 32'(0));
        chk({tag, "_index"}, 32'(m_index), 32'(v.idx));
        chk({tag, "_addr_start"}, 32'(m_addr), 32'(0));
        @(negedge clk);
        chk({tag, "_ready_after_arm"}, 32'(m_ready), 32'(v.len != 16'd0));
        for (int k = 0; k < int'(v.len); k++) begin
            feed(v.bytes[8*k +: 8], (k == 1) ? int'(v.stall_n) : 0, k);
            if (k == 0 && v.poke) begin
                start    = 1'b1;
                index_in = 8'hEE;
                length   = 25'd7;
                @(negedge clk);
                start    = 1'b0;
                index_in = v.idx;
                length   = 25'(v.len);
                chk({tag, "_index_after_poke"}, 32'(m_index), 32'(v.idx));
            end
        end
        n = 0;
        while (m_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (m_busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: busy got 1 expected 0", tag);
        end
        repeat (2) @(negedge clk);
        chk({tag, "_wr_count"}, 32'(rise_cyc.size()), 32'(v.len));
        for (int k = 0; k < int'(v.len); k++) begin
            if (k < rise_cyc.size()) begin
                chk($sformatf("%s_rise%0d_cyc", tag, k), 32'(rise_cyc[k] - t0), 32'(v.acc[8*k +: 8]));
                chk($sformatf("%s_rise%0d_addr", tag, k), 32'(rise_addr[k]), 32'(k));
                chk($sformatf("%s_rise%0d_dout", tag, k), 32'(rise_dout[k]), 32'(v.bytes[8*k +: 8]));
            end
            if (k < widths.size())
                chk($sformatf("%s_wr%0d_width", tag, k), 32'(widths[k]), 32'(v.wr_w));
        end
        chk({tag, "_dl_fall"}, 32'(fall_cyc - t0), 32'(v.fall));
        chk({tag, "_done_count"}, 32'(done_cnt), 32'(1));
        chk({tag, "_done_cyc"}, 32'(done_cyc - t0), 32'(v.fall));
        chk({tag, "_dl_end"}, 32'(m_dl), 32'(0));
        chk({tag, "_index_held"}, 32'(m_index), 32'(v.idx));
        exp_last = (v.len == 16'd0) ? 0 : int'(v.len) - 1;
        chk({tag, "_addr_end"}, 32'(m_addr), 32'(exp_last));
        sel = 1'b0;
    endtask

    vec_t vecs[7];
    vec_t post_rst;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        sel       = 1'b0;
        index_in  = 8'h00;
        length    = 25'd0;
        src_data  = 8'h00;
        src_valid = 1'b0;

        vecs[0] = mk(1'b0, 8'h00, 16'd3, 32'h00F03CA5, 32'h00140B02, 8'd32, 4'd1, 8'd0,  1'b0);
        vecs[1] = mk(1'b0, 8'h00, 16'd3, 32'h00F03CA5, 32'h00201702, 8'd44, 4'd1, 8'd20, 1'b0);
        vecs[2] = mk(1'b0, 8'h5A, 16'd0, 32'h00000000, 32'h00000000, 8'd5,  4'd1, 8'd0,  1'b0);
        vecs[3] = mk(1'b0, 8'h10, 16'd3, 32'h00665544, 32'h00140B02, 8'd32, 4'd1, 8'd0,  1'b1);
        vecs[4] = mk(1'b0, 8'hC3, 16'd4, 32'h80040201, 32'h1D140B02, 8'd41, 4'd1, 8'd0,  1'b0);
        vecs[5] = mk(1'b0, 8'h01, 16'd1, 32'h000000FF, 32'h00000002, 8'd14, 4'd1, 8'd0,  1'b0);
        vecs[6] = mk(1'b1, 8'h77, 16'd3, 32'h00332211, 32'h000C0702, 8'd20, 4'd3, 8'd0,  1'b0);
        post_rst = mk(1'b0, 8'h01, 16'd2, 32'h0000BC9A, 32'h00000B02, 8'd23, 4'd1, 8'd0, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_download", 32'(d_dl), 32'(0));
        chk("rst_wr", 32'(d_wr), 32'(0));
        chk("rst_busy", 32'(d_busy), 32'(0));
        chk("rst_ready", 32'(d_ready), 32'(0));
        chk("rst_done", 32'(d_done), 32'(0));
        chk("rst_addr", 32'(d_addr), 32'(0));
        chk("rst_index", 32'(d_index), 32'(0));
        chk("rst_dout", 32'(d_dout), 32'(0));
        chk("rst_v_busy", 32'(v_busy), 32'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // reset while the first strobe is high
        sel = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        index_in = 8'h42;
        length   = 25'd3;
        @(negedge clk);
        start = 1'b0;
        feed(8'hAB, 0, 0);
        chk("mid_wr_before_reset", 32'(d_wr), 32'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_download", 32'(d_dl), 32'(0));
        chk("mid_rst_wr", 32'(d_wr), 32'(0));
        chk("mid_rst_busy", 32'(d_busy), 32'(0));
        chk("mid_rst_ready", 32'(d_ready), 32'(0));
        chk("mid_rst_done", 32'(d_done), 32'(0));
        chk("mid_rst_addr", 32'(d_addr), 32'(0));
        chk("mid_rst_index", 32'(d_index), 32'(0));
        chk("mid_rst_dout", 32'(d_dout), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_vec("post_rst", post_rst);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
